// File: rtl/chunk_sequencer.sv
// chunk_sequencer: fills a CELL_SIZE-row chunk buffer from a raster pixel stream, then issues
// the transposed result one cell per handshake. Define CHUNK_SEQ_ALIGN_CHECK_EN to check pix_eol.
package types_pkg;
  typedef logic [7:0] pixel;
endpackage

module chunk_sequencer
  import types_pkg::*;
#(
  parameter int CELL_SIZE  = 2,
  parameter int CHUNK_SIZE = 64
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  pixel                                             pix_in,
  input  logic                                             pix_valid,
  input  logic                                             pix_eol,
  output logic                                             pix_ready,
  output pixel [CELL_SIZE-1:0][CHUNK_SIZE-1:0][CELL_SIZE-1:0] video_chunk,
  input  pixel [CHUNK_SIZE-1:0][CELL_SIZE-1:0][CELL_SIZE-1:0] processing_chunk,
  output pixel [CELL_SIZE-1:0][CELL_SIZE-1:0]              cell_out,
  output logic                                             cell_valid,
  input  logic                                             cell_ready,
  output logic [$clog2(CHUNK_SIZE)-1:0]                    cell_idx,
  output logic                                             cell_last,
  output logic                                             align_err
);

  // CELL_SIZE and CHUNK_SIZE are powers of two (>= 2) so col splits into cell / pixel fields.
  localparam int ROW_LEN = CELL_SIZE * CHUNK_SIZE;
  localparam int COL_W   = $clog2(ROW_LEN);
  localparam int ROW_W   = $clog2(CELL_SIZE);
  localparam int PIX_W   = $clog2(CELL_SIZE);
  localparam int IDX_W   = $clog2(CHUNK_SIZE);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LEN - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(CELL_SIZE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHUNK_SIZE - 1);

  typedef enum logic {FILL, EMIT} state_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             accept;
  logic             handshake;
  logic             early_eol;

  assign accept    = pix_valid && pix_ready;
  assign handshake = cell_valid && cell_ready;
  assign cell_out  = processing_chunk[cell_idx];

`ifdef CHUNK_SEQ_ALIGN_CHECK_EN
  assign early_eol = pix_eol && (col != COL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      align_err <= 1'b0;
    end else if (state == FILL && accept && (pix_eol != (col == COL_LAST))) begin
      align_err <= 1'b1;
    end
  end
`else
  logic unused_eol;
  assign unused_eol = pix_eol;
  assign early_eol  = 1'b0;
  assign align_err  = 1'b0;
`endif

  // pix_ready is registered, so it stays low for the first cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      col         <= '0;
      row         <= '0;
      cell_idx    <= '0;
      pix_ready   <= 1'b0;
      cell_valid  <= 1'b0;
      cell_last   <= 1'b0;
      video_chunk <= '0;
    end else begin
      case (state)
        FILL: begin
          pix_ready <= 1'b1;
          if (accept) begin
            if (early_eol) begin
              col <= '0;
            end else begin
              video_chunk[row][col[COL_W-1:PIX_W]][col[PIX_W-1:0]] <= pix_in;
              if (col == COL_LAST) begin
                col <= '0;
                if (row == ROW_LAST) begin
                  row        <= '0;
                  state      <= EMIT;
                  pix_ready  <= 1'b0;
                  cell_valid <= 1'b1;
                  cell_idx   <= '0;
                  cell_last  <= 1'b0;
                end else begin
                  row <= row + 1'b1;
                end
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        EMIT: begin
          if (handshake) begin
            if (cell_idx == IDX_LAST) begin
              state      <= FILL;
              cell_valid <= 1'b0;
              cell_last  <= 1'b0;
              cell_idx   <= '0;
              pix_ready  <= 1'b1;
              row        <= '0;
              col        <= '0;
            end else begin
              cell_idx  <= cell_idx + 1'b1;
              cell_last <= (cell_idx == IDX_LAST - 1'b1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/chunk_sequencer.md
# chunk_sequencer

Controller for the chunk transposer datapath. It collects a raster pixel stream of CELL_SIZE rows × (CELL_SIZE·CHUNK_SIZE) pixels into a chunk buffer and drives that buffer onto the transposer's `video_chunk` input. It then reads the transposer's `processing_chunk` result back and issues it one CELL_SIZE×CELL_SIZE cell per handshake to the upscaling stage. The block sits between the video input stream and the per-cell processing pipeline.

## Interface
Parameters:
- CELL_SIZE, 2, cell edge in pixels (rows per chunk, pixels per cell row)
- CHUNK_SIZE, 64, cells per chunk; row length ROW_LEN = CELL_SIZE·CHUNK_SIZE

Ports (`pixel` type from types.sv):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous reset, active-high
- pix_in  in  pixel  input pixel
- pix_valid  in  1  pix_in valid
- pix_eol  in  1  pix_in is last pixel of its row
- pix_ready  out  1  sequencer accepts pix_in
- video_chunk  out  pixel[CELL_SIZE-1:0][CHUNK_SIZE-1:0][CELL_SIZE-1:0]  chunk buffer, to transposer
- processing_chunk  in  pixel[CHUNK_SIZE-1:0][CELL_SIZE-1:0][CELL_SIZE-1:0]  transposer result
- cell_out  out  pixel[CELL_SIZE-1:0][CELL_SIZE-1:0]  current cell
- cell_valid  out  1  cell_out valid
- cell_ready  in  1  downstream accepts cell
- cell_idx  out  $clog2(CHUNK_SIZE)  index of current cell in chunk
- cell_last  out  1  current cell is index CHUNK_SIZE-1
- align_err  out  1  sticky alignment error (CHUNK_SEQ_ALIGN_CHECK_EN only)

## Operation
- Two states: FILL, EMIT. Reset state FILL.
- Counters: col (0..ROW_LEN-1), row (0..CELL_SIZE-1), cell_idx (0..CHUNK_SIZE-1).
- FILL: pix_ready=1. On pix_valid&&pix_ready, write video_chunk[row][col/CELL_SIZE][col%CELL_SIZE] ← pix_in. col++; at col=ROW_LEN-1, col←0, row++. Accept at row=CELL_SIZE-1, col=ROW_LEN-1 → EMIT, cell_idx←0.
- EMIT: pix_ready=0; pix_valid ignored; video_chunk not written. cell_valid=1, cell_out=processing_chunk[cell_idx] (combinational mux from registered cell_idx). On cell_valid&&cell_ready: cell_idx++. Handshake at cell_idx=CHUNK_SIZE-1 → FILL, row/col/cell_idx←0.
- cell_last = EMIT && cell_idx==CHUNK_SIZE-1.
- cell_out, cell_idx, cell_last stay stable while cell_valid && !cell_ready.
- Buffer is not cleared between chunks; every entry is overwritten before the next EMIT.

## Timing
- Reset values: pix_ready=0 while rst high, then 1 (FILL); cell_valid=0, cell_idx=0, cell_last=0, align_err=0, video_chunk all zero; cell_out = processing_chunk[0].
- Fill: exactly CELL_SIZE·ROW_LEN accepted beats (256 at defaults); input gaps allowed.
- cell_valid rises the cycle after the final pixel is accepted; the first cell is available with 1-cycle latency.
- Emit: CHUNK_SIZE handshakes, minimum CHUNK_SIZE cycles.
- pix_ready rises the cycle after the last cell handshake. No fill/emit overlap; minimum period is 320 cycles per chunk at defaults.
- Transposer is combinational; processing_chunk must settle within one cycle of video_chunk.
- Reset mid-operation: all state returns to reset values immediately; the partial chunk is discarded.

## Configuration
- CHUNK_SEQ_ALIGN_CHECK_EN defined: pix_eol is checked on every accepted beat.
  - Early eol (col<ROW_LEN-1): the partial row is discarded, col←0, row unchanged, and align_err is set.
  - Missing eol at col=ROW_LEN-1: the row is accepted normally and align_err is set.
  - align_err is sticky and cleared only by rst.
- Not defined: pix_eol is ignored, rows are delimited purely by count, and align_err is tied to 0.

## Test plan
- Reset, then stream 256 beats pix_in=row·128+col with cell_ready=1 → cell_valid the cycle after beat 256; cell k = {{2k,2k+1},{128+2k,129+2k}} as [row][pixel]; cell_last only at k=63; pix_ready=1 the next cycle.
- Hold cell_ready=0 for 10 cycles at cell_idx=5 → cell_out, cell_idx stable; all 64 cells delivered once, in order.
- pix_valid 50% random during fill → output identical to scenario 1; second back-to-back chunk also correct.
- pix_valid=1 with new data throughout EMIT → pix_ready=0, video_chunk unchanged, cells unaffected.
- Assert rst at fill beat 100 and again at emit cell 30 → outputs at reset values; the next 256 beats yield a correct chunk with no stale data.
- With CHUNK_SEQ_ALIGN_CHECK_EN: pix_eol at col 50 of row 0 → align_err=1, row 0 refilled from col 0, then the correct chunk is emitted. Without the macro, the same stimulus → align_err=0 and pix_eol is ignored.
